// File: rtl/pipelined_mix_design.sv
// Pipelined WIDTH-bit mixing datapath with valid/ready backpressure and an
// LFSR/MISR built-in self-test that reuses the same pipeline registers.
module pipelined_mix_design #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 4,
  parameter int               BIST_LEN  = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic [WIDTH-1:0] signature
);

  localparam int CNT_W = (BIST_LEN > 1) ? $clog2(BIST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] x, input int k);
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    r1 = {x[WIDTH-2:0], x[WIDTH-1]};
    r2 = {x[WIDTH-3:0], x[WIDTH-1:WIDTH-2]};
    return r1 ^ (x & r2) ^ WIDTH'(k + 1);
  endfunction

  state_t                       state_q, state_d;
  logic [WIDTH-1:0]             in_data_q, in_data_d;
  logic                         in_vld_q, in_vld_d;
  logic [STAGES-1:0][WIDTH-1:0] stg_data_q, stg_data_d;
  logic [STAGES-1:0]            stg_vld_q, stg_vld_d;
  logic [WIDTH-1:0]             out_data_q, out_data_d;
  logic                         out_vld_q, out_vld_d;
  logic [WIDTH-1:0]             lfsr_q, lfsr_d;
  logic [WIDTH-1:0]             sig_q, sig_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic busy;
  logic idle_like;
  logic stall;
  logic flush;
  logic upstream_vld;

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign stall     = out_vld_q && !out_ready && !busy;
  assign flush     = idle_like && bist_start;

  assign in_ready  = idle_like && !stall;
  assign data_out  = out_data_q;
  assign out_valid = out_vld_q;
  assign signature = sig_q;
  assign bist_busy = busy;
  assign bist_done = (state_q == DONE);

  // Anything still valid ahead of the final stage means the drain is not over.
  always_comb begin
    upstream_vld = in_vld_q;
    for (int k = 0; k < STAGES - 1; k++) begin
      upstream_vld = upstream_vld | stg_vld_q[k];
    end
  end

  always_comb begin
    in_data_d  = in_data_q;
    in_vld_d   = in_vld_q;
    stg_data_d = stg_data_q;
    stg_vld_d  = stg_vld_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    if (!stall) begin
      if (busy) begin
        in_vld_d = (state_q == RUN);
        if (state_q == RUN) begin
          in_data_d = lfsr_q;
        end
      end else begin
        in_vld_d = in_valid;
        if (in_valid) begin
          in_data_d = data_in;
        end
      end
      stg_data_d[0] = mix(in_data_q, 0);
      stg_vld_d[0]  = in_vld_q;
      for (int k = 1; k < STAGES; k++) begin
        stg_data_d[k] = mix(stg_data_q[k-1], k);
        stg_vld_d[k]  = stg_vld_q[k-1];
      end
      // BIST results never reach the functional output port.
      out_vld_d = stg_vld_q[STAGES-1] && !busy;
      if (!busy) begin
        out_data_d = stg_data_q[STAGES-1];
      end
    end
    if (flush) begin
      in_vld_d  = 1'b0;
      stg_vld_d = '0;
      out_vld_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d = RUN;
          lfsr_d  = WIDTH'(1);
          sig_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIST_LEN - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stg_vld_q[STAGES-1] && !upstream_vld) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (busy && stg_vld_q[STAGES-1]) begin
      sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ stg_data_q[STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_vld_q   <= 1'b0;
      stg_data_q <= '0;
      stg_vld_q  <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      lfsr_q     <= WIDTH'(1);
      sig_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      in_vld_q   <= in_vld_d;
      stg_data_q <= stg_data_d;
      stg_vld_q  <= stg_vld_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      lfsr_q     <= lfsr_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipelined_mix_design.sv
// Directed bench for pipelined_mix_design: table-driven functional vectors,
// backpressure streaming, and BIST signature / reset corner cases.
module tb_pipelined_mix_design;

  localparam int STAGES = 4;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       bist_start = 1'b0;

  logic       in_ready, out_valid, bist_busy, bist_done;
  logic [7:0] data_out, signature;
  logic       in_ready3, out_valid3, bist_busy3, bist_done3;
  logic [7:0] data_out3, signature3;

  int   checks = 0;
  int   passed = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  // Golden BIST_LEN=1 signature is 0x1A; the BIST_LEN=3 instance exercises the
  // LFSR sequence 0x01, 0xB8, 0x5C and ends at 0xB6.
  pipelined_mix_design #(.WIDTH(8), .STAGES(STAGES), .BIST_LEN(1), .LFSR_TAPS(8'hB8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
    .signature(signature)
  );

  pipelined_mix_design #(.WIDTH(8), .STAGES(STAGES), .BIST_LEN(3), .LFSR_TAPS(8'hB8)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready3),
    .data_out(data_out3), .out_valid(out_valid3), .out_ready(out_ready),
    .bist_start(bist_start), .bist_busy(bist_busy3), .bist_done(bist_done3),
    .signature(signature3)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] din);
    data_in  = din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic runVector(input string tag, input vec_t v);
    applyStimulus(v.din);
    repeat (STAGES) tick();
    checkOutput({tag, "_early_valid"}, out_valid, 1'b0);
    tick();
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_data"}, data_out, v.dout);
    checkOutput({tag, "_data_b"}, data_out3, v.dout);
    tick();
  endtask

  task automatic streamTest();
    logic [7:0] expq[$];
    logic [7:0] prevData;
    logic       prevStall;
    int         sent;
    int         got;
    int         cyc;
    sent = 0; got = 0; cyc = 0; prevStall = 1'b0; prevData = 8'h00;
    while (got < 10 && cyc < 200) begin
      out_ready = (((cyc / 3) % 2) == 0);
      if (sent < 10) begin
        in_valid = 1'b1;
        data_in  = vecs[sent % 5].din;
      end else begin
        in_valid = 1'b0;
        data_in  = 8'h00;
      end
      #1;
      checkOutput("stream_in_ready", in_ready, !(out_valid && !out_ready));
      if (prevStall) begin
        checkOutput("stall_hold_valid", out_valid, 1'b1);
        checkOutput("stall_hold_data", data_out, prevData);
      end
      if (out_valid && out_ready) begin
        checkOutput("stream_expected_pending", 8'(expq.size() != 0), 8'd1);
        if (expq.size() != 0) checkOutput("stream_data", data_out, expq.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(vecs[sent % 5].dout);
        sent++;
      end
      prevStall = out_valid && !out_ready;
      prevData  = data_out;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", 8'(got), 8'd10);
    got = 0;
    repeat (10) begin
      tick();
      if (out_valid) got++;
    end
    checkOutput("stream_no_extra", 8'(got), 8'd0);
  endtask

  task automatic bistRun(input string tag, input bit pulseInRun, input bit junkIn);
    bist_start = 1'b1;
    tick();
    bist_start = pulseInRun;
    if (junkIn) begin
      in_valid = 1'b1;
      data_in  = 8'hA5;
    end
    checkOutput({tag, "_busy_e0"}, bist_busy, 1'b1);
    checkOutput({tag, "_sig_clear"}, signature, 8'h00);
    checkOutput({tag, "_sig_clear_b"}, signature3, 8'h00);
    for (int e = 1; e <= 8; e++) begin
      tick();
      bist_start = 1'b0;
      if (e == 5) begin
        in_valid = 1'b0;
        data_in  = 8'h00;
      end
      checkOutput({tag, "_out_valid_low"}, out_valid, 1'b0);
      checkOutput({tag, "_out_valid_low_b"}, out_valid3, 1'b0);
      if (e == 3) checkOutput({tag, "_in_ready_busy"}, in_ready, 1'b0);
      if (e == 5) begin
        checkOutput({tag, "_busy_e5"}, bist_busy, 1'b1);
        checkOutput({tag, "_done_e5"}, bist_done, 1'b0);
      end
      if (e == 6) begin
        checkOutput({tag, "_busy_e6"}, bist_busy, 1'b0);
        checkOutput({tag, "_done_e6"}, bist_done, 1'b1);
        checkOutput({tag, "_sig"}, signature, 8'h1A);
        checkOutput({tag, "_busy_b_e6"}, bist_busy3, 1'b1);
      end
      if (e == 7) begin
        checkOutput({tag, "_done_b_e7"}, bist_done3, 1'b0);
        checkOutput({tag, "_sig_b_e7"}, signature3, 8'hBB);
      end
      if (e == 8) begin
        checkOutput({tag, "_done_b"}, bist_done3, 1'b1);
        checkOutput({tag, "_sig_b"}, signature3, 8'hB6);
        checkOutput({tag, "_sig_held"}, signature, 8'h1A);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    vecs[0] = '{8'h00, 8'h02};
    vecs[1] = '{8'hFF, 8'h02};
    vecs[2] = '{8'h01, 8'h1A};
    vecs[3] = '{8'hB8, 8'h8F};
    vecs[4] = '{8'h5C, 8'hC1};

    #2;
    checkOutput("rst_data_out", data_out, 8'h00);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_signature", signature, 8'h00);
    checkOutput("rst_bist_done", bist_done, 1'b0);
    checkOutput("rst_bist_busy", bist_busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_in_ready_b", in_ready3, 1'b1);

    for (int i = 0; i < 5; i++) runVector($sformatf("vec%0d", i), vecs[i]);

    streamTest();

    bistRun("bist", 1'b0, 1'b1);
    bistRun("retrig", 1'b1, 1'b0);
    bistRun("rerun", 1'b0, 1'b0);

    // A word two stages deep when BIST starts must never emerge.
    applyStimulus(8'h01);
    tick();
    bistRun("inflight", 1'b0, 1'b0);
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("inflight_dropped", 8'(seen), 8'd0);

    runVector("after_bist", vecs[0]);

    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    repeat (2) tick();
    #3 rst = 1'b0;
    #1;
    checkOutput("midrun_rst_busy", bist_busy, 1'b0);
    checkOutput("midrun_rst_busy_b", bist_busy3, 1'b0);
    checkOutput("midrun_rst_data_out", data_out, 8'h00);
    checkOutput("midrun_rst_out_valid", out_valid, 1'b0);
    checkOutput("midrun_rst_done", bist_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    checkOutput("midrun_rst_in_ready", in_ready, 1'b1);
    bistRun("fresh", 1'b0, 1'b0);

    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    repeat (7) tick();
    #3 rst = 1'b0;
    #1;
    checkOutput("late_rst_done", bist_done, 1'b0);
    checkOutput("late_rst_sig", signature, 8'h00);
    checkOutput("late_rst_sig_b", signature3, 8'h00);
    checkOutput("late_rst_busy_b", bist_busy3, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    checkOutput("late_rst_sig_b_after", signature3, 8'h00);
    checkOutput("late_rst_done_b_after", bist_done3, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
